// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port scheduler.
//   DW   : data width of one register
//   AW   : register pointer width
//   NREG : number of architectural registers (2**AW)
//   rf_ptr_t / rf_data_t : pointer and data types
//   src_e : write source (ALU writeback or load return)
package rf_pkg;

    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;

    typedef logic [AW-1:0] rf_ptr_t;
    typedef logic [DW-1:0] rf_data_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: one pending bit per register, set when a load is issued
// and cleared once that load's data has been written to the register file.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   ld_issue        : memory stage issues a load
//   ld_issue_ptr    : destination of the issued load
//   ld_issue_ready  : issue accepted (destination not already pending)
//   clr_en, clr_ptr : load-sourced register-file write in progress this cycle
//   alu_ptr         : ALU destination, checked for a pending load
//   alu_blocked     : ALU destination awaits a load (WAW hold)
//   rd_ptr_a/b      : decode read pointers; rd_b_const masks pointer B
//   stall           : a decode operand is pending
//   pend_cnt        : number of pending registers
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_issue_ptr,
    output logic          ld_issue_ready,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_ptr,
    input  logic [AW-1:0] alu_ptr,
    output logic          alu_blocked,
    input  logic [AW-1:0] rd_ptr_a,
    input  logic [AW-1:0] rd_ptr_b,
    input  logic          rd_b_const,
    output logic          stall,
    output logic [AW:0]   pend_cnt
);

    logic [NREG-1:0] pending;
    logic            set_en;
    logic            clr_hit;

    // r0 is hard-wired: issues to it are accepted but never tracked, so
    // pending[0] stays 0 for ever.
    assign ld_issue_ready = !pending[ld_issue_ptr] || (ld_issue_ptr == '0);
    assign set_en         = ld_issue && ld_issue_ready && (ld_issue_ptr != '0);

    // A clear only counts when it removes a set bit and is not overridden
    // by a same-edge set of the same pointer (set has priority).
    assign clr_hit = clr_en && pending[clr_ptr] &&
                     !(set_en && (ld_issue_ptr == clr_ptr));

    assign alu_blocked = pending[alu_ptr];
    assign stall       = pending[rd_ptr_a] || (!rd_b_const && pending[rd_ptr_b]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (clr_hit)
                pending[clr_ptr] <= 1'b0;
            if (set_en)
                pending[ld_issue_ptr] <= 1'b1;
            if (set_en && !clr_hit)
                pend_cnt <= pend_cnt + 1'b1;
            else if (!set_en && clr_hit)
                pend_cnt <= pend_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/rf_wr_sched.sv
// Write-port scheduler for the 32 x 8-bit register file. Arbitrates the
// single write port between ALU writeback and load return (round-robin),
// registers the winning write, and tracks outstanding loads so decode can
// stall on operands that are still in flight.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   alu_valid/ptr/data, alu_ready : ALU writeback handshake
//   ld_valid/ptr/data, ld_ready   : load-return handshake
//   ld_issue, ld_issue_ptr, ld_issue_ready : load issue into scoreboard
//   rd_ptr_a, rd_ptr_b, rd_b_const, stall  : decode operand stall
//   rf_we, rf_ptr_w, rf_di      : registered register-file write port
//   pend_cnt                    : number of pending registers
module rf_wr_sched
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_ptr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_ptr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_issue_ptr,
    output logic          ld_issue_ready,
    input  logic [AW-1:0] rd_ptr_a,
    input  logic [AW-1:0] rd_ptr_b,
    input  logic          rd_b_const,
    output logic          stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_ptr_w,
    output logic [DW-1:0] rf_di,
    output logic [AW:0]   pend_cnt
);

    src_e     last_grant;
    src_e     src_p1;
    logic     alu_blocked;
    logic     alu_elig;
    logic     ld_elig;
    logic     grant;
    rf_ptr_t  grant_ptr;
    rf_data_t grant_data;

    // ALU writes to a register awaiting a load are held (WAW guard);
    // load returns are never blocked.
    assign alu_elig = alu_valid && !alu_blocked;
    assign ld_elig  = ld_valid;

    // On a conflict, the source that did not win last time goes first.
    assign alu_ready = alu_elig && (!ld_elig || (last_grant == SRC_LD));
    assign ld_ready  = ld_elig && (!alu_elig || (last_grant == SRC_ALU));
    assign grant     = alu_ready || ld_ready;

    assign grant_ptr  = ld_ready ? ld_ptr  : alu_ptr;
    assign grant_data = ld_ready ? ld_data : alu_data;

    // Stage p1: registered write port, one cycle after the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_ptr_w   <= '0;
            rf_di      <= '0;
            src_p1     <= SRC_ALU;
            last_grant <= SRC_LD;
        end else begin
            // r0 writes complete their handshake but never reach the file.
            rf_we <= grant && (grant_ptr != '0);
            if (grant) begin
                rf_ptr_w   <= grant_ptr;
                rf_di      <= grant_data;
                src_p1     <= ld_ready ? SRC_LD : SRC_ALU;
                last_grant <= ld_ready ? SRC_LD : SRC_ALU;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .ld_issue       (ld_issue),
        .ld_issue_ptr   (ld_issue_ptr),
        .ld_issue_ready (ld_issue_ready),
        .clr_en         (rf_we && (src_p1 == SRC_LD)),
        .clr_ptr        (rf_ptr_w),
        .alu_ptr        (alu_ptr),
        .alu_blocked    (alu_blocked),
        .rd_ptr_a       (rd_ptr_a),
        .rd_ptr_b       (rd_ptr_b),
        .rd_b_const     (rd_b_const),
        .stall          (stall),
        .pend_cnt       (pend_cnt)
    );

endmodule

// File: tb/tb_rf_wr_sched.sv
// Directed bench for rf_wr_sched: write latency, round-robin arbitration,
// load scoreboard stall/clear timing, WAW hold, r0 handling and async reset.
module tb_rf_wr_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [4:0] alu_ptr;
    logic [7:0] alu_data;
    logic       alu_ready;
    logic       ld_valid;
    logic [4:0] ld_ptr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_issue;
    logic [4:0] ld_issue_ptr;
    logic       ld_issue_ready;
    logic [4:0] rd_ptr_a;
    logic [4:0] rd_ptr_b;
    logic       rd_b_const;
    logic       stall;
    logic       rf_we;
    logic [4:0] rf_ptr_w;
    logic [7:0] rf_di;
    logic [5:0] pend_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rf_wr_sched dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ptr        (alu_ptr),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .ld_valid       (ld_valid),
        .ld_ptr         (ld_ptr),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .ld_issue       (ld_issue),
        .ld_issue_ptr   (ld_issue_ptr),
        .ld_issue_ready (ld_issue_ready),
        .rd_ptr_a       (rd_ptr_a),
        .rd_ptr_b       (rd_ptr_b),
        .rd_b_const     (rd_b_const),
        .stall          (stall),
        .rf_we          (rf_we),
        .rf_ptr_w       (rf_ptr_w),
        .rf_di          (rf_di),
        .pend_cnt       (pend_cnt)
    );

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled one more #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_ptr = 0; alu_data = 0;
        ld_valid = 0;  ld_ptr = 0;  ld_data = 0;
        ld_issue = 0;  ld_issue_ptr = 0;
        rd_ptr_a = 0;  rd_ptr_b = 0; rd_b_const = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        vectors++;
        if (rf_ptr_w !== 5'd0 || rf_di !== 8'd0) begin miscompares++; $display("FAIL reset_ptr_di got=%0d/%h exp=0/00", rf_ptr_w, rf_di); end
        vectors++;
        if (pend_cnt !== 6'd0 || stall !== 1'b0) begin miscompares++; $display("FAIL reset_pend got=%0d stall=%b exp=0/0", pend_cnt, stall); end
    endtask

    task automatic test_alu_write();
        do_reset();
        alu_valid = 1; alu_ptr = 3; alu_data = 8'h5A;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_ready got=%b exp=1", alu_ready); end
        step();
        alu_valid = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_ptr_w !== 5'd3 || rf_di !== 8'h5A) begin miscompares++; $display("FAIL alu_write got we=%b ptr=%0d di=%h exp 1/3/5a", rf_we, rf_ptr_w, rf_di); end
        step();
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_ptr_w !== 5'd3 || rf_di !== 8'h5A) begin miscompares++; $display("FAIL alu_write_idle got we=%b ptr=%0d di=%h exp 0/3/5a", rf_we, rf_ptr_w, rf_di); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alu_valid = 1; alu_ptr = 1; alu_data = 8'h11;
        ld_valid = 1;  ld_ptr = 2;  ld_data = 8'h22;
        #1;
        vectors++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin miscompares++; $display("FAIL rr_first got alu=%b ld=%b exp 1/0", alu_ready, ld_ready); end
        step();
        #1;
        vectors++;
        if (alu_ready !== 1'b0 || ld_ready !== 1'b1) begin miscompares++; $display("FAIL rr_second got alu=%b ld=%b exp 0/1", alu_ready, ld_ready); end
        vectors++;
        if (rf_we !== 1'b1 || rf_ptr_w !== 5'd1 || rf_di !== 8'h11) begin miscompares++; $display("FAIL rr_wr1 got we=%b ptr=%0d di=%h exp 1/1/11", rf_we, rf_ptr_w, rf_di); end
        step();
        alu_valid = 0; ld_valid = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_ptr_w !== 5'd2 || rf_di !== 8'h22) begin miscompares++; $display("FAIL rr_wr2 got we=%b ptr=%0d di=%h exp 1/2/22", rf_we, rf_ptr_w, rf_di); end
        step();
        #1;
        vectors++;
        if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rr_idle got we=%b exp 0", rf_we); end
    endtask

    task automatic test_load_scoreboard();
        do_reset();
        ld_issue = 1; ld_issue_ptr = 4; rd_ptr_a = 4;
        #1;
        vectors++;
        if (ld_issue_ready !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("FAIL issue_r4 got rdy=%b stall=%b exp 1/0", ld_issue_ready, stall); end
        step();
        ld_issue = 0;
        #1;
        vectors++;
        if (stall !== 1'b1 || pend_cnt !== 6'd1) begin miscompares++; $display("FAIL pend_r4 got stall=%b cnt=%0d exp 1/1", stall, pend_cnt); end
        // WAW hold and refused re-issue while r4 is pending
        alu_valid = 1; alu_ptr = 4; alu_data = 8'h44;
        ld_issue = 1;  ld_issue_ptr = 4;
        #1;
        vectors++;
        if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL waw_hold got=%b exp 0", alu_ready); end
        vectors++;
        if (ld_issue_ready !== 1'b0) begin miscompares++; $display("FAIL reissue got=%b exp 0", ld_issue_ready); end
        step();
        ld_issue = 0;
        #1;
        vectors++;
        if (pend_cnt !== 6'd1) begin miscompares++; $display("FAIL reissue_cnt got=%0d exp 1", pend_cnt); end
        // Load return granted in cycle N
        ld_valid = 1; ld_ptr = 4; ld_data = 8'h7F;
        #1;
        vectors++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin miscompares++; $display("FAIL ld_ret got ld=%b alu=%b exp 1/0", ld_ready, alu_ready); end
        step();
        ld_valid = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_ptr_w !== 5'd4 || rf_di !== 8'h7F) begin miscompares++; $display("FAIL ld_wr got we=%b ptr=%0d di=%h exp 1/4/7f", rf_we, rf_ptr_w, rf_di); end
        vectors++;
        if (stall !== 1'b1 || alu_ready !== 1'b0 || pend_cnt !== 6'd1) begin miscompares++; $display("FAIL ld_n1 got stall=%b alu=%b cnt=%0d exp 1/0/1", stall, alu_ready, pend_cnt); end
        step();
        #1;
        vectors++;
        if (stall !== 1'b0 || pend_cnt !== 6'd0) begin miscompares++; $display("FAIL ld_n2 got stall=%b cnt=%0d exp 0/0", stall, pend_cnt); end
        vectors++;
        if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL waw_release got=%b exp 1", alu_ready); end
        step();
        alu_valid = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_ptr_w !== 5'd4 || rf_di !== 8'h44) begin miscompares++; $display("FAIL waw_wr got we=%b ptr=%0d di=%h exp 1/4/44", rf_we, rf_ptr_w, rf_di); end
    endtask

    task automatic test_r0_and_const();
        do_reset();
        alu_valid = 1; alu_ptr = 0; alu_data = 8'hFF;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL r0_alu_ready got=%b exp 1", alu_ready); end
        step();
        alu_valid = 0;
        ld_issue = 1; ld_issue_ptr = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b0) begin miscompares++; $display("FAIL r0_we got=%b exp 0", rf_we); end
        vectors++;
        if (ld_issue_ready !== 1'b1) begin miscompares++; $display("FAIL r0_issue_ready got=%b exp 1", ld_issue_ready); end
        step();
        ld_issue_ptr = 5;
        #1;
        vectors++;
        if (pend_cnt !== 6'd0) begin miscompares++; $display("FAIL r0_cnt got=%0d exp 0", pend_cnt); end
        step();
        ld_issue = 0;
        rd_ptr_a = 0; rd_ptr_b = 5; rd_b_const = 1;
        #1;
        vectors++;
        if (stall !== 1'b0 || pend_cnt !== 6'd1) begin miscompares++; $display("FAIL b_const got stall=%b cnt=%0d exp 0/1", stall, pend_cnt); end
        rd_b_const = 0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL b_reg got stall=%b exp 1", stall); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ld_issue = 1; ld_issue_ptr = 6;
        step();
        ld_issue_ptr = 7;
        step();
        ld_issue_ptr = 8;
        alu_valid = 1; alu_ptr = 9; alu_data = 8'h99;
        step();
        ld_issue = 0; alu_valid = 0; rd_ptr_a = 6;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || pend_cnt !== 6'd3 || stall !== 1'b1) begin miscompares++; $display("FAIL pre_reset got we=%b cnt=%0d stall=%b exp 1/3/1", rf_we, pend_cnt, stall); end
        reset = 1;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || stall !== 1'b0 || pend_cnt !== 6'd0) begin miscompares++; $display("FAIL async_reset got we=%b stall=%b cnt=%0d exp 0/0/0", rf_we, stall, pend_cnt); end
        step();
        reset = 0;
        #1;
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_load_scoreboard();
        test_r0_and_const();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_wr_sched.md
Name: rf_wr_sched

Overview:
- Write-port scheduler and load scoreboard for the 8-bit, 32-entry register file.
- Shares the single register-file write port between two requesters: ALU writeback and memory-load return. Uses valid/ready handshakes and round-robin arbitration.
- Tracks registers with an outstanding load and raises a read stall so the decode stage never reads stale data.
- Sits between execute/memory stages and the register file's di/we/ptr_w inputs.

Parameters:
- DW, 8, data width of a register
- AW, 5, register pointer width
- NREG, 32, number of architectural registers (2**AW)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ptr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load-return write request
- ld_ptr  in  AW  load destination register
- ld_data  in  DW  loaded byte
- ld_ready  out  1  load request accepted this cycle
- ld_issue  in  1  memory stage issues a load (marks destination pending)
- ld_issue_ptr  in  AW  destination of issued load
- ld_issue_ready  out  1  issue accepted (destination not already pending)
- rd_ptr_a  in  AW  decode read pointer A
- rd_ptr_b  in  AW  decode read pointer B
- rd_b_const  in  1  operand B is an immediate; ignore rd_ptr_b
- stall  out  1  a decode operand is pending
- rf_we  out  1  register-file write enable (registered)
- rf_ptr_w  out  AW  register-file write pointer (registered)
- rf_di  out  DW  register-file write data (registered)
- pend_cnt  out  AW+1  number of pending registers

Behaviour:
- Reset, asynchronous: rf_we=0, rf_ptr_w=0, rf_di=0, pending vector all 0, pend_cnt=0, last_grant=LD (ALU wins the first conflict).
- Handshake: a request transfers in the cycle where valid&&ready. Ready is combinational from the current state and the inputs. Requesters hold ptr/data stable while valid&&!ready.
- Arbitration, one grant per cycle:
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one not equal to last_grant is granted.
  - last_grant updates only on a grant.
- ALU eligibility: alu_valid && !pending[alu_ptr]. This is a WAW guard: an ALU write to a register awaiting a load is held until the load completes.
- Load eligibility: ld_valid. A load return is never blocked by the scoreboard.
- Write latency: a grant in cycle N gives rf_we=1 with the granted rf_ptr_w and rf_di during cycle N+1. With no grant, rf_we=0 in N+1 and ptr/data hold their last values.
- r0: a granted write with ptr==0 completes its handshake, but rf_we stays 0 in N+1.
- Scoreboard set: ld_issue && ld_issue_ready sets pending[ld_issue_ptr] at the clock edge.
  - ld_issue_ready = !pending[ld_issue_ptr] || ld_issue_ptr==0.
  - Issue to r0 is accepted and never sets a bit.
- Scoreboard clear: pending[p] clears at the edge ending the cycle in which rf_we=1 with rf_ptr_w=p and the write came from the LD source. The source is registered alongside rf_we.
  - Consequence: stall drops in cycle N+2 after a grant in N.
- Same-edge set and clear of the same pointer: set wins. This cannot occur legally, because the issue is refused while the bit is set; keep the priority for robustness.
- stall = pending[rd_ptr_a] || (!rd_b_const && pending[rd_ptr_b]). Pointer 0 is never pending. Combinational.
- pend_cnt: +1 on set, -1 on clear, unchanged when both or neither occur. Range 0..31.
- Reset mid-transfer: every pending bit and every in-flight write (rf_we) is dropped. Requesters must reissue.

Decomposition:
- Shared package rf_pkg holds:
  - DW, AW, NREG
  - typedef rf_ptr_t = logic[AW-1:0], rf_data_t = logic[DW-1:0]
  - enum src_e {SRC_ALU, SRC_LD}
- One sub-module, rf_scoreboard: pending vector, set/clear logic, pend_cnt, stall and ld_issue_ready generation.
- Arbitration and write-port registers stay in rf_wr_sched.

Test Plan:
- Reset, then ALU write r3=0x5A (alu_valid one cycle) -> alu_ready=1 that cycle; next cycle rf_we=1, rf_ptr_w=3, rf_di=0x5A; following cycle rf_we=0.
- ALU (r1=0x11) and LD (r2=0x22) both valid for 2 cycles after reset -> ALU granted first, then LD; rf_we pulses r1/0x11 then r2/0x22; alu_ready and ld_ready each high exactly once.
- ld_issue r4; decode rd_ptr_a=4 -> stall=1, pend_cnt=1. LD return r4=0x7F granted in N -> rf_we in N+1, stall=0 and pend_cnt=0 in N+2.
- r4 pending; alu_valid with alu_ptr=4 -> alu_ready=0 until the load's rf_we cycle passes; then granted. Second ld_issue to r4 while pending -> ld_issue_ready=0, pend_cnt stays 1.
- rd_ptr_b=4 pending with rd_b_const=1 -> stall=0. ALU write to r0=0xFF -> alu_ready=1, rf_we stays 0. ld_issue r0 -> ld_issue_ready=1, pend_cnt stays 0.
- Reset asserted asynchronously while rf_we=1 and 3 registers pending -> rf_we=0, stall=0, pend_cnt=0 immediately, without waiting for a clock edge.
